tri_note_sequencer: RTL and testbench
=====================================

Name: tri_note_sequencer

Overview:
- Plays a stored sequence of notes on one tri_wave generator. Each step holds a pitch and a duration.
- Per step: programs the generator's max_val, releases its reset for the note's duration, then holds it in reset for a short articulation gap.
- Sits between the host/control logic and tri_wave. Owns pattern storage, step sequencing, start/stop and looping.

Parameters:
DEPTH, 16, number of pattern steps (power of two; AW = log2(DEPTH))
DUR_W, 16, width of per-step duration field
GAP_CYCLES, 4, cycles of forced generator reset between notes (0 = no gap)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  pattern write strobe
wr_addr  input  AW  pattern write address
wr_pitch  input  8  step pitch (max_val for tri_wave); 0 = rest
wr_dur  input  DUR_W  step duration in clock cycles; 0 treated as 1
seq_len  input  AW+1  number of steps to play, 1..DEPTH; sampled at start
start  input  1  single-cycle start request
stop  input  1  abort request
loop_en  input  1  sampled at end of last step; 1 = wrap to step 0
max_val  output  8  pitch to tri_wave max_val
gen_reset  output  1  active-high reset to tri_wave
busy  output  1  sequence running
step_idx  output  AW  index of step being played
done  output  1  one-cycle pulse on natural completion

Behaviour:
- Reset values (async on reset_n low): max_val=0, gen_reset=1, busy=0, step_idx=0, done=0, state IDLE. Pattern RAM contents are not reset.
- Pattern RAM: DEPTH x (8+DUR_W) registers, synchronous write.
  - wr_en is honoured only while busy=0. Writes while busy are dropped.
- States: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE:
  - gen_reset=1, max_val=0.
  - start=1 with seq_len in 1..DEPTH: latch seq_len, step_idx<=0, busy<=1, go to LOAD.
  - seq_len=0 or >DEPTH: start is ignored.
- LOAD (1 cycle): read RAM[step_idx]; max_val<=pitch; dur_cnt<=max(dur,1)-1; go to PLAY.
- PLAY:
  - gen_reset=0 if pitch!=0. Pitch 0 is a rest: gen_reset=1, max_val=0.
  - dur_cnt decrements each cycle. At dur_cnt==0, go to GAP, or directly to next-step logic if GAP_CYCLES=0.
  - gen_reset is low for exactly dur cycles.
- GAP: gen_reset=1, max_val held; lasts GAP_CYCLES cycles.
- Next-step logic:
  - If step_idx < len-1: step_idx+1, go to LOAD.
  - Else if loop_en=1: step_idx<=0, go to LOAD.
  - Else go to DONE.
- DONE (1 cycle): done=1, busy<=0, gen_reset=1, max_val<=0, go to IDLE.
- Timing: start sampled at edge k → busy=1 after k. Pitch appears on max_val and gen_reset falls after edge k+1.
- stop=1 in any non-IDLE state: next edge go to IDLE, gen_reset=1, max_val=0, busy=0, no done pulse.
- stop and start in the same cycle: stop wins, start is dropped.
- start while busy is ignored. stop while IDLE has no effect.
- Arithmetic: dur_cnt is DUR_W bits, no wrap. step_idx wraps only through the loop path.

Optional Feature:
- Macro: TRI_SEQ_TEMPO_EN.
- When defined:
  - Adds input tempo_div[7:0].
  - An internal prescaler produces a tick every tempo_div+1 cycles.
  - dur_cnt decrements only on tick, so one duration unit = tempo_div+1 clocks.
  - The prescaler clears on entry to LOAD.
  - GAP stays in raw clock cycles.
- When undefined: no port; dur_cnt decrements every cycle (equivalent to tempo_div=0).

Decomposition:
- Package tri_seq_pkg holds:
  - state enum (IDLE, LOAD, PLAY, GAP, DONE)
  - step record typedef (pitch[7:0], dur[DUR_W-1:0])
  - default parameter constants
- Natural sub-module: tri_seq_pattern_ram, the DEPTH-entry register file with write gating.
- FSM, counters and the optional prescaler stay in the top level.

Test Plan:
1. Write step0 (pitch 20, dur 5), seq_len=1, loop_en=0, start → max_val=20, gen_reset low exactly 5 cycles, 4 gap cycles, done pulse 1 cycle, busy low, max_val=0.
2. Steps 0–2 (pitch 10/0/30, dur 3/2/4), seq_len=3 → step_idx 0,1,2. Step 1 keeps gen_reset high (rest). Total busy cycles = 1 + 3×1 (LOAD) + 9 (dur) + 3×4 (gap) = 25.
3. loop_en=1, seq_len=2 → after step 1, step_idx returns to 0 with no done pulse. Deassert loop_en → completes after the next step 1 with done=1.
4. stop asserted mid-PLAY of step 1 → next cycle busy=0, gen_reset=1, max_val=0, done never pulses. Simultaneous start+stop in IDLE → stays IDLE.
5. wr_en to step 0 while busy → RAM unchanged (replay shows old pitch). wr_dur=0 → gen_reset low 1 cycle. seq_len=0 start → ignored.
6. Assert reset_n low mid-sequence (asynchronous, between edges) → outputs immediately take reset values. With TRI_SEQ_TEMPO_EN, tempo_div=3, dur=2 → gen_reset low 8 cycles.

Source files
------------

// File: rtl/tri_note_sequencer_pkg.sv
// Shared types and default sizing for the tri-wave note sequencer.
// No logic: enums, step record and parameter defaults only.
// Optional tempo prescaler is enabled elsewhere with TRI_SEQ_TEMPO_EN.
package tri_seq_pkg;

  localparam int DEPTH_DEF      = 16;
  localparam int DUR_W_DEF      = 16;
  localparam int GAP_CYCLES_DEF = 4;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

  // One pattern step at the default duration width
  typedef struct packed {
    logic [7:0]           pitch;
    logic [DUR_W_DEF-1:0] dur;
  } step_t;

endpackage

// File: rtl/tri_note_sequencer_if.sv
// Host-side bundle for the note sequencer: pattern writes, run control, generator drive.
// Pure wiring, no latency.
// Macro TRI_SEQ_TEMPO_EN adds the tempo_div input.
interface tri_note_sequencer_if import tri_seq_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DUR_W = DUR_W_DEF
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [7:0]       wr_pitch;
  logic [DUR_W-1:0] wr_dur;
  logic [AW:0]      seq_len;
  logic             start;
  logic             stop;
  logic             loop_en;
`ifdef TRI_SEQ_TEMPO_EN
  logic [7:0]       tempo_div;
`endif
  logic [7:0]       max_val;
  logic             gen_reset;
  logic             busy;
  logic [AW-1:0]    step_idx;
  logic             done;

  modport master (
    output wr_en, wr_addr, wr_pitch, wr_dur, seq_len, start, stop, loop_en,
`ifdef TRI_SEQ_TEMPO_EN
    output tempo_div,
`endif
    input  max_val, gen_reset, busy, step_idx, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_pitch, wr_dur, seq_len, start, stop, loop_en,
`ifdef TRI_SEQ_TEMPO_EN
    input  tempo_div,
`endif
    output max_val, gen_reset, busy, step_idx, done
  );

endinterface

// File: rtl/tri_note_sequencer_pattern_ram.sv
// Pattern store: DEPTH steps of pitch + duration, synchronous write, async read.
// Write takes effect on the next edge; read is combinational.
// Writes are dropped while the sequencer is busy so a running pattern never changes.
module tri_seq_pattern_ram import tri_seq_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic                     i_busy,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [7:0]               i_wr_pitch,
  input  logic [DUR_W-1:0]         i_wr_dur,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [7:0]               o_rd_pitch,
  output logic [DUR_W-1:0]         o_rd_dur
);

  logic [7:0]       r_pitch [DEPTH];
  logic [DUR_W-1:0] r_dur   [DEPTH];

  // Store a step only when the sequencer is idle; contents survive reset
  always_ff @(posedge clk) begin
    if (i_wr_en && !i_busy) begin
      r_pitch[i_wr_addr] <= i_wr_pitch;
      r_dur[i_wr_addr]   <= i_wr_dur;
    end
  end

  assign o_rd_pitch = r_pitch[i_rd_addr];
  assign o_rd_dur   = r_dur[i_rd_addr];

endmodule

// File: rtl/tri_note_sequencer.sv
// Steps through a stored pattern, driving tri_wave max_val and its reset per note.
// Pitch appears two edges after start; each step costs 1 load + dur + GAP_CYCLES cycles.
// No backpressure; stop aborts at the next edge. TRI_SEQ_TEMPO_EN adds a tempo prescaler.
module tri_note_sequencer import tri_seq_pkg::*; #(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int DUR_W      = DUR_W_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  tri_note_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [GW-1:0]    GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GW-1:0]    GAP_ONE   = GW'(1);
  localparam logic [AW:0]      DEPTH_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0]      LEN_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]    IDX_ONE   = AW'(1);
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);

  state_t           r_state;
  logic [AW:0]      r_len;
  logic [DUR_W-1:0] r_dur_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic [7:0]       r_max_val;
  logic             r_gen_reset;
  logic             r_busy;
  logic [AW-1:0]    r_step_idx;
  logic             r_done;

  logic [7:0]       w_rd_pitch;
  logic [DUR_W-1:0] w_rd_dur;
  logic [DUR_W-1:0] w_dur_m1;
  logic             w_len_ok;
  logic             w_more;
  logic             w_tick;
  logic             w_step_end;
  state_t           w_adv_state;
  logic [AW-1:0]    w_adv_idx;

  tri_seq_pattern_ram #(
    .DEPTH (DEPTH),
    .DUR_W (DUR_W)
  ) u_ram (
    .clk        (clk),
    .i_wr_en    (bus.wr_en),
    .i_busy     (r_busy),
    .i_wr_addr  (bus.wr_addr),
    .i_wr_pitch (bus.wr_pitch),
    .i_wr_dur   (bus.wr_dur),
    .i_rd_addr  (r_step_idx),
    .o_rd_pitch (w_rd_pitch),
    .o_rd_dur   (w_rd_dur)
  );

`ifdef TRI_SEQ_TEMPO_EN
  logic [7:0] r_pre;

  assign w_tick = (r_pre == bus.tempo_div);

  // Duration prescaler: runs only in PLAY, so it is zero on every entry from LOAD
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
    end else if (r_state != ST_PLAY || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 8'd1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // A zero duration still plays for one unit
  assign w_dur_m1 = (w_rd_dur == '0) ? '0 : (w_rd_dur - DUR_ONE);
  assign w_len_ok = (bus.seq_len != '0) && (bus.seq_len <= DEPTH_LEN);
  assign w_more   = (({1'b0, r_step_idx} + LEN_ONE) < r_len);

  // The current step finishes this edge (end of gap, or end of note when there is no gap)
  assign w_step_end = ((r_state == ST_PLAY) && w_tick && (r_dur_cnt == '0) && (GAP_CYCLES == 0)) ||
                      ((r_state == ST_GAP) && (r_gap_cnt == '0));

  // Where to go after a step: next step, wrap on loop, or finish
  always_comb begin
    w_adv_state = ST_DONE;
    w_adv_idx   = r_step_idx;
    if (w_more) begin
      w_adv_state = ST_LOAD;
      w_adv_idx   = r_step_idx + IDX_ONE;
    end else if (bus.loop_en) begin
      w_adv_state = ST_LOAD;
      w_adv_idx   = '0;
    end
  end

  // Sequencer FSM with registered generator drive and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_dur_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_max_val   <= '0;
      r_gen_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_step_idx  <= '0;
      r_done      <= 1'b0;
    end else if ((r_state != ST_IDLE) && bus.stop) begin
      r_state     <= ST_IDLE;
      r_max_val   <= '0;
      r_gen_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done      <= 1'b0;
          r_gen_reset <= 1'b1;
          r_max_val   <= '0;
          if (bus.start && !bus.stop && w_len_ok) begin
            r_len      <= bus.seq_len;
            r_step_idx <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_max_val   <= w_rd_pitch;
          r_gen_reset <= (w_rd_pitch == 8'd0);
          r_dur_cnt   <= w_dur_m1;
          r_state     <= ST_PLAY;
        end
        ST_PLAY: begin
          if (w_tick) begin
            if (r_dur_cnt != '0) begin
              r_dur_cnt <= r_dur_cnt - DUR_ONE;
            end else begin
              r_gen_reset <= 1'b1;
              if (GAP_CYCLES > 0) begin
                r_gap_cnt <= GAP_LOAD;
                r_state   <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_ONE;
          end
        end
        ST_DONE: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_gen_reset <= 1'b1;
          r_max_val   <= '0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      if (w_step_end) begin
        r_state    <= w_adv_state;
        r_step_idx <= w_adv_idx;
        if (w_adv_state == ST_DONE) begin
          r_done    <= 1'b1;
          r_max_val <= '0;
        end
      end
    end
  end

  assign bus.max_val   = r_max_val;
  assign bus.gen_reset = r_gen_reset;
  assign bus.busy      = r_busy;
  assign bus.step_idx  = r_step_idx;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_tri_note_sequencer.sv
// Bench for tri_note_sequencer: directed scenarios plus randomized patterns.
// Expected per-cycle outputs are built from a step-list model of the pattern.
// Build with TRI_SEQ_TEMPO_EN to also exercise the tempo prescaler.
module tb_tri_note_sequencer;
  import tri_seq_pkg::*;

  localparam int DEPTH = 16;
  localparam int DUR_W = 16;
  localparam int GAP   = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   tdiv    = 0;
  int   bc;

  step_t model_ram [DEPTH];

  tri_note_sequencer_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();

  tri_note_sequencer #(
    .DEPTH      (DEPTH),
    .DUR_W      (DUR_W),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_vec++;
    if (obs_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs_v, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int dn, input int bz, input int gr, input int idx, input int mv);
    return {17'd0, dn[0], bz[0], gr[0], idx[3:0], mv[7:0]};
  endfunction

  function automatic logic [31:0] obs(input bit with_idx);
    return {17'd0, bus.done, bus.busy, bus.gen_reset, (with_idx ? bus.step_idx : 4'd0), bus.max_val};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tempo(input int t);
    tdiv = t;
`ifdef TRI_SEQ_TEMPO_EN
    bus.tempo_div = t[7:0];
`endif
  endtask

  task automatic wr(input int a, input int p, input int d);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = a[3:0];
    bus.wr_pitch = p[7:0];
    bus.wr_dur   = d[15:0];
    step();
    bus.wr_en = 1'b0;
    model_ram[a].pitch = p[7:0];
    model_ram[a].dur   = d[15:0];
  endtask

  // Start a run and check every cycle against the expected waveform.
  // stop_at / rst_at (>=0) abort the run after that trace index.
  task automatic play(input int len, input int passes, input int stop_at, input int rst_at,
                      output int busy_cyc);
    logic [31:0] q[$];
    int mv_prev;
    int last_start;
    int p;
    int d;
    mv_prev    = 0;
    last_start = 0;
    busy_cyc   = 0;
    for (int ps = 0; ps < passes; ps++) begin
      if (ps == passes - 1) last_start = q.size();
      for (int s = 0; s < len; s++) begin
        p = model_ram[s].pitch;
        d = model_ram[s].dur;
        if (d == 0) d = 1;
        d = d * (tdiv + 1);
        q.push_back(pk(0, 1, 1, s, mv_prev));
        for (int c = 0; c < d; c++) q.push_back(pk(0, 1, (p == 0) ? 1 : 0, s, p));
        for (int c = 0; c < GAP; c++) q.push_back(pk(0, 1, 1, s, p));
        mv_prev = p;
      end
    end
    q.push_back(pk(1, 1, 1, len - 1, 0));

    bus.seq_len = len[4:0];
    bus.loop_en = (passes > 1);
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      // A write while busy must be dropped
      bus.wr_en    = (i == 1);
      bus.wr_addr  = 4'd0;
      bus.wr_pitch = model_ram[0].pitch ^ 8'h5a;
      bus.wr_dur   = 16'd9;
      if (passes > 1 && i == last_start) bus.loop_en = 1'b0;
      if (bus.busy) busy_cyc++;
      chk("trace", obs(1), q[i]);
      if (i == stop_at) begin
        bus.stop = 1'b1;
        step();
        bus.stop    = 1'b0;
        bus.wr_en   = 1'b0;
        bus.loop_en = 1'b0;
        chk("stop_idle", obs(0), pk(0, 0, 1, 0, 0));
        for (int k = 0; k < 3; k++) begin
          step();
          chk("stop_quiet", obs(0), pk(0, 0, 1, 0, 0));
        end
        return;
      end
      if (i == rst_at) begin
        #2;
        reset_n   = 1'b0;
        bus.wr_en = 1'b0;
        #1;
        chk("async_rst", obs(1), pk(0, 0, 1, 0, 0));
        #1;
        reset_n     = 1'b1;
        bus.loop_en = 1'b0;
        step();
        chk("post_rst", obs(1), pk(0, 0, 1, 0, 0));
        return;
      end
      step();
    end
    bus.wr_en   = 1'b0;
    bus.loop_en = 1'b0;
    chk("idle_after", obs(0), pk(0, 0, 1, 0, 0));
  endtask

  initial begin
    int len;
    int passes;
    int sa;
    int ra;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_pitch = '0;
    bus.wr_dur   = '0;
    bus.seq_len  = '0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.loop_en  = 1'b0;
    set_tempo(0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset", obs(1), pk(0, 0, 1, 0, 0));
    reset_n = 1'b1;
    step();

    // Single note
    wr(0, 20, 5);
    play(1, 1, -1, -1, bc);
    chk("t1_busy", bc, 11);

    // Three notes with a rest in the middle
    wr(0, 10, 3);
    wr(1, 0, 2);
    wr(2, 30, 4);
    play(3, 1, -1, -1, bc);
    chk("t2_busy", bc, 25);

    // Looping over two steps, three passes
    play(2, 3, -1, -1, bc);

    // Stop in the middle of step 1's note
    play(3, 1, 9, -1, bc);

    // Start and stop together while idle
    bus.seq_len = 5'd2;
    bus.start   = 1'b1;
    bus.stop    = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("start_stop", obs(0), pk(0, 0, 1, 0, 0));
    step();
    chk("start_stop2", obs(0), pk(0, 0, 1, 0, 0));

    // Zero duration plays one cycle
    wr(0, 7, 0);
    play(1, 1, -1, -1, bc);
    chk("dur0_busy", bc, 7);

    // Illegal lengths are ignored
    bus.seq_len = 5'd0;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    chk("len0", obs(0), pk(0, 0, 1, 0, 0));
    bus.seq_len = 5'd17;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    chk("len17", obs(0), pk(0, 0, 1, 0, 0));

    // Async reset mid-sequence, then replay from preserved pattern
    wr(0, 10, 3);
    play(3, 1, -1, 10, bc);
    play(3, 1, -1, -1, bc);

`ifdef TRI_SEQ_TEMPO_EN
    set_tempo(3);
    wr(0, 20, 2);
    play(1, 1, -1, -1, bc);
    chk("tempo_busy", bc, 14);
    set_tempo(0);
`endif

    // Randomized patterns
    for (int it = 0; it < 24; it++) begin
      len    = $urandom_range(1, 6);
      passes = $urandom_range(1, 2);
      for (int s = 0; s < len; s++) begin
        wr(s, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255), $urandom_range(0, 5));
      end
`ifdef TRI_SEQ_TEMPO_EN
      set_tempo($urandom_range(0, 2));
`endif
      sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
      ra = (sa < 0 && $urandom_range(0, 9) == 0) ? $urandom_range(3, 6) : -1;
      play(len, passes, sa, ra, bc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
